fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the PikaRISC pipeline. It sits directly upstream of the register file and the execute path. It owns the architectural fetch PC, issues one instruction-memory request at a time, and hands fetched instructions to decode/execute over a valid/ready handshake. It also publishes the current fetch PC to the register file's fetch PC port and accepts PC redirects from writeback on the same `wb_pc_write_en`/`wb_pc_in` pair the register file consumes.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `PC_STEP`, default 4: PC increment per delivered instruction.
- `clk` in 1: rising-edge clock.
- `reset` in 1: reset, synchronous, active-low.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 32: word-aligned fetch address (= `pc`).
- `imem_rsp_valid` in 1: response valid; single-cycle pulse, no backpressure.
- `imem_rsp_data` in 32: instruction word.
- `id_valid` out 1: instruction buffer holds a deliverable instruction.
- `id_ready` in 1: downstream consumes the buffer this cycle.
- `id_instr` out 32: buffered instruction.
- `id_pc` out 32: address of `id_instr`.
- `rf_pc_out` out 32: current fetch PC, driven to the register file's `if_pc_in`.
- `wb_pc_write_en` in 1: redirect strobe from writeback.
- `wb_pc_in` in 32: redirect target; bits [1:0] are ignored and forced to 0.
- `fetch_count` out 32: number of instructions delivered (`id_valid && id_ready`), wrapping.

## Operation
- State register `state` ∈ {REQ, WAIT, HOLD, DRAIN}. Also `pc[31:0]`, an instruction buffer (`id_instr`, `id_pc`), and `fetch_count`.
- REQ: `imem_req_valid=1`, `imem_req_addr=pc`. On `imem_req_ready`, go to WAIT.
- WAIT: `imem_req_valid=0`. On `imem_rsp_valid`: `id_instr<=imem_rsp_data`, `id_pc<=pc`, `pc<=pc+PC_STEP`, go to HOLD.
- HOLD: `id_valid=1`. On `id_ready`: increment `fetch_count` and go to REQ.
- DRAIN: waits for the response to a discarded request. On `imem_rsp_valid`, drop the data and go to REQ. Otherwise stay in DRAIN.
- Redirect (`wb_pc_write_en=1`) has priority over every other transition in the same cycle. It sets `pc<={wb_pc_in[31:2],2'b00}` and clears the buffer, so `id_valid` is 0 next cycle.
  - From REQ with `imem_req_ready=1` in the same cycle: the request is in flight, so go to DRAIN.
  - From REQ with `imem_req_ready=0`: go to REQ.
  - From WAIT with `imem_rsp_valid=0`: go to DRAIN.
  - From WAIT with `imem_rsp_valid=1` in the same cycle: drop the response and go to REQ.
  - From HOLD: a concurrent `id_ready` is not a handoff (`fetch_count` unchanged). Go to REQ.
  - From DRAIN: update `pc`. If `imem_rsp_valid=1`, go to REQ; otherwise stay in DRAIN.
- Arithmetic: `pc+PC_STEP` is modulo 2^32 (32'hFFFF_FFFC+4 → 0). `fetch_count` wraps 32'hFFFF_FFFF → 0.
- `rf_pc_out = pc` at all times.
- At most one request is outstanding. Responses arriving in REQ or HOLD are protocol violations and are ignored.

## Timing
- Reset (`reset=0` at a rising edge): `state=REQ`, `pc=RESET_PC`, `fetch_count=0`, `id_valid=0`, `id_instr=0`, `id_pc=0`. `imem_req_valid` is forced to 0 while `reset=0`.
- First request: `imem_req_valid=1` in the first cycle with `reset=1`.
- Latency with `imem_req_ready=1` and a 1-cycle memory: request in cycle N, response in N+1, `id_valid=1` in N+2. Steady-state throughput is 1 instruction per 3 cycles with `id_ready=1`.
- All outputs are registered except `imem_req_valid`, `imem_req_addr`, and `rf_pc_out`, which decode directly from `state`/`pc`.
- `id_instr`/`id_pc` are stable while `id_valid=1 && id_ready=0`.
- Reset mid-operation (any state, including DRAIN) returns to reset values at that edge. Any in-flight memory response after reset is ignored until the first request is accepted.
- First valid post-redirect request: next cycle if leaving REQ/WAIT/HOLD directly. If in DRAIN, the cycle after the stale response.

## Test plan
- Reset then straight-line fetch: `RESET_PC=0`, ready memory returning `addr^32'hA5A5_0000`. Expect `id_pc` 0, 4, 8 with matching `id_instr`, `id_valid` at cycles 3/6/9 after reset release, and `fetch_count=3`.
- Backpressure: hold `id_ready=0` for 5 cycles in HOLD. Expect `id_valid`, `id_instr`, `id_pc` stable, no new `imem_req_valid`, and `pc` already advanced to `id_pc+4`.
- Redirect in WAIT: `wb_pc_in=32'h0000_0103` while waiting, stale response 2 cycles later. Expect the stale data is never delivered, the next request address is 32'h0000_0100, and the next `id_pc=32'h100`.
- Redirect coincident with handoff in HOLD (`id_ready=1`, `wb_pc_write_en=1`). Expect `fetch_count` unchanged, `id_valid=0` next cycle, and a request to the target.
- Wrap: `RESET_PC=32'hFFFF_FFFC`. Expect the second request address 32'h0000_0000, and `fetch_count` wrapping after preload via 2^32 deliveries (or a forced value).
- Reset asserted in DRAIN: expect `state=REQ`, `pc=RESET_PC`, `id_valid=0`, and the late response ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PikaRISC instruction fetch stage with single outstanding request and redirect
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] rf_pc_out,
    input  logic        wb_pc_write_en,
    input  logic [31:0] wb_pc_in,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] STEP      = 32'(PC_STEP);
    localparam logic [31:0] PC_AT_RST = {RESET_PC[31:2], 2'b00};

    state_t      state_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        id_valid_q;
    logic [31:0] id_instr_q;
    logic [31:0] id_pc_q;
    logic        handoff;
    logic        unused_wb_lsb;

    // Redirect target ignores the two low bits of the writeback value.
    assign unused_wb_lsb = ^wb_pc_in[1:0];

    // A handoff only counts when no redirect lands in the same cycle.
    assign handoff = (state_q == S_HOLD) && id_ready && !wb_pc_write_en;

    // Next fetch PC: redirect wins, otherwise advance when the live response is captured.
    always_comb begin
        pc_d = pc_q;
        if (wb_pc_write_en) begin
            pc_d = {wb_pc_in[31:2], 2'b00};
        end else if (state_q == S_WAIT && imem_rsp_valid) begin
            pc_d = pc_q + STEP;
        end
    end

    // Delivered-instruction counter, wrapping modulo 2^32.
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (handoff) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // Fetch FSM together with PC, instruction buffer and delivery counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_REQ;
            pc_q          <= PC_AT_RST;
            fetch_count_q <= 32'd0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= 32'd0;
            id_pc_q       <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            if (wb_pc_write_en) begin
                // Redirect flushes the buffer; an accepted-but-unanswered request must be drained.
                id_valid_q <= 1'b0;
                id_instr_q <= 32'd0;
                id_pc_q    <= 32'd0;
                case (state_q)
                    S_REQ:   state_q <= imem_req_ready ? S_DRAIN : S_REQ;
                    S_WAIT:  state_q <= imem_rsp_valid ? S_REQ : S_DRAIN;
                    S_HOLD:  state_q <= S_REQ;
                    S_DRAIN: state_q <= imem_rsp_valid ? S_REQ : S_DRAIN;
                    default: state_q <= S_REQ;
                endcase
            end else begin
                case (state_q)
                    S_REQ: begin
                        if (imem_req_ready) begin
                            state_q <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rsp_valid) begin
                            id_instr_q <= imem_rsp_data;
                            id_pc_q    <= pc_q;
                            id_valid_q <= 1'b1;
                            state_q    <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (id_ready) begin
                            id_valid_q <= 1'b0;
                            state_q    <= S_REQ;
                        end
                    end
                    S_DRAIN: begin
                        // Stale response is dropped; only then may a new request go out.
                        if (imem_rsp_valid) begin
                            state_q <= S_REQ;
                        end
                    end
                    default: state_q <= S_REQ;
                endcase
            end
        end
    end

    // Request and PC outputs decode straight from state/pc; request is masked during reset.
    always_comb begin
        imem_req_valid = reset && (state_q == S_REQ);
        imem_req_addr  = pc_q;
        rf_pc_out      = pc_q;
    end

    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a transaction-level model
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] rf_pc_out;
    logic        wb_pc_write_en;
    logic [31:0] wb_pc_in;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .rf_pc_out      (rf_pc_out),
        .wb_pc_write_en (wb_pc_write_en),
        .wb_pc_in       (wb_pc_in),
        .fetch_count    (fetch_count)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Architectural model: fetch PC, one-entry buffer, outstanding request and its epoch validity.
    logic [31:0] m_pc       = RST_PC;
    logic        m_buf_full = 1'b0;
    logic [31:0] m_buf_pc   = 32'd0;
    logic [31:0] m_buf_data = 32'd0;
    logic        m_out      = 1'b0;
    logic        m_stale    = 1'b0;
    logic [31:0] m_count    = 32'd0;

    // Memory: one pending response with a countdown.
    logic        mem_pend  = 1'b0;
    int          mem_cnt   = 0;
    logic [31:0] mem_data  = 32'd0;
    int          mem_delay = 1;
    logic        data_rand = 1'b0;

    logic        chk_en = 1'b0;
    int          cyc = 0;
    logic        obs_idv, obs_rv;
    logic [31:0] obs_addr, obs_idpc, obs_fc, obs_pc;
    logic [31:0] acc_log[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    // rr/ir: 0 or 1 fixed, 2 random.
    task automatic step(input logic rst_v, input int rr, input int ir,
                        input logic we, input logic [31:0] wpc);
        logic        req_exp, acc, rsp, dlv;
        logic [31:0] rdata;
        @(negedge clk);
        if (rst_v) cyc++; else cyc = 0;
        reset          = rst_v;
        imem_req_ready = (rr == 2) ? 1'($urandom_range(0, 1)) : (rr != 0);
        id_ready       = (ir == 2) ? 1'($urandom_range(0, 1)) : (ir != 0);
        wb_pc_write_en = we;
        wb_pc_in       = wpc;
        rsp            = mem_pend && (mem_cnt == 1);
        rdata          = rsp ? mem_data : $urandom;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rdata;
        #1;
        req_exp  = rst_v && !m_buf_full && !m_out;
        obs_idv  = id_valid;
        obs_rv   = imem_req_valid;
        obs_addr = imem_req_addr;
        obs_idpc = id_pc;
        obs_fc   = fetch_count;
        obs_pc   = rf_pc_out;
        if (chk_en) begin
            check_eq("req_valid", 32'(imem_req_valid), 32'(req_exp));
            if (req_exp) check_eq("req_addr", imem_req_addr, m_pc);
            check_eq("rf_pc", rf_pc_out, m_pc);
            check_eq("id_valid", 32'(id_valid), 32'(m_buf_full));
            if (m_buf_full) begin
                check_eq("id_pc", id_pc, m_buf_pc);
                check_eq("id_instr", id_instr, m_buf_data);
            end
            check_eq("fetch_count", fetch_count, m_count);
        end
        if (mem_pend) begin
            if (mem_cnt == 1) mem_pend = 1'b0;
            else mem_cnt--;
        end
        if (!rst_v) begin
            m_pc = RST_PC; m_buf_full = 1'b0; m_buf_pc = 32'd0; m_buf_data = 32'd0;
            m_out = 1'b0; m_stale = 1'b0; m_count = 32'd0;
        end else begin
            acc = req_exp && imem_req_ready;
            dlv = m_buf_full && id_ready && !we;
            if (dlv) begin
                m_buf_full = 1'b0;
                m_count    = m_count + 32'd1;
            end
            if (rsp && m_out) begin
                if (!m_stale && !we) begin
                    m_buf_full = 1'b1;
                    m_buf_pc   = m_pc;
                    m_buf_data = rdata;
                    m_pc       = m_pc + 32'd4;
                end
                m_out = 1'b0;
            end
            if (acc) begin
                acc_log.push_back(m_pc);
                m_out    = 1'b1;
                m_stale  = 1'b0;
                mem_pend = 1'b1;
                mem_cnt  = (mem_delay == 0) ? $urandom_range(1, 3) : mem_delay;
                mem_data = data_rand ? $urandom : (m_pc ^ 32'hA5A5_0000);
            end
            if (we) begin
                m_pc       = {wpc[31:2], 2'b00};
                m_buf_full = 1'b0;
                if (m_out) m_stale = 1'b1;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        logic [31:0] saved;
        reset = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b0;
        wb_pc_write_en = 1'b0; wb_pc_in = 32'd0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;

        // Reset, then straight-line fetch with a 1-cycle memory.
        step(1'b0, 0, 0, 1'b0, 32'd0);
        chk_en = 1'b1;
        step(1'b0, 1, 0, 1'b0, 32'd0);
        check_eq("rst_req_valid", 32'(obs_rv), 32'd0);
        mem_delay = 1;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1, 1, 1'b0, 32'd0);
            check_eq("lat_idv", 32'(obs_idv), 32'((cyc % 3) == 0));
            if (cyc == 3 || cyc == 6 || cyc == 9)
                check_eq("line_idpc", obs_idpc, 32'((cyc / 3 - 1) * 4));
        end
        step(1'b1, 1, 0, 1'b0, 32'd0);
        check_eq("count3", obs_fc, 32'd3);

        // Backpressure in HOLD.
        for (int i = 0; i < 10 && !m_buf_full; i++) step(1'b1, 1, 0, 1'b0, 32'd0);
        check_eq("bp_reached", 32'(m_buf_full), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1, 0, 1'b0, 32'd0);
            check_eq("bp_pc", obs_pc, m_buf_pc + 32'd4);
            check_eq("bp_noreq", 32'(obs_rv), 32'd0);
        end
        step(1'b1, 1, 1, 1'b0, 32'd0);

        // Redirect in WAIT with a stale response two cycles later.
        mem_delay = 3;
        for (int i = 0; i < 10 && !m_out; i++) step(1'b1, 1, 0, 1'b0, 32'd0);
        mem_delay = 1;
        step(1'b1, 0, 0, 1'b1, 32'h0000_0103);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1, 0, 1'b0, 32'd0);
            if (obs_rv) break;
        end
        check_eq("redir_addr", obs_addr, 32'h0000_0100);
        for (int i = 0; i < 10 && !obs_idv; i++) step(1'b1, 1, 0, 1'b0, 32'd0);
        check_eq("redir_idpc", obs_idpc, 32'h0000_0100);

        // Redirect coinciding with a handoff in HOLD.
        saved = m_count;
        step(1'b1, 1, 1, 1'b1, 32'h0000_0200);
        step(1'b1, 1, 1, 1'b0, 32'd0);
        check_eq("hold_redir_cnt", obs_fc, saved);
        check_eq("hold_redir_idv", 32'(obs_idv), 32'd0);
        check_eq("hold_redir_addr", obs_addr, 32'h0000_0200);

        // PC wrap at the top of the address space.
        step(1'b1, 0, 1, 1'b1, 32'hFFFF_FFFF);
        acc_log.delete();
        for (int i = 0; i < 12; i++) step(1'b1, 1, 1, 1'b0, 32'd0);
        check_eq("wrap_n", 32'(acc_log.size() >= 2), 32'd1);
        if (acc_log.size() >= 2) begin
            check_eq("wrap_a0", acc_log[0], 32'hFFFF_FFFC);
            check_eq("wrap_a1", acc_log[1], 32'h0000_0000);
        end

        // Reset asserted in DRAIN; late response must be ignored.
        mem_delay = 3;
        for (int i = 0; i < 10 && !m_out; i++) step(1'b1, 1, 0, 1'b0, 32'd0);
        step(1'b1, 0, 0, 1'b1, 32'h0000_0300);
        step(1'b0, 0, 0, 1'b0, 32'd0);
        step(1'b1, 0, 0, 1'b0, 32'd0);
        check_eq("drain_rst_pc", obs_pc, RST_PC);
        check_eq("drain_rst_idv", 32'(obs_idv), 32'd0);
        check_eq("drain_rst_req", 32'(obs_rv), 32'd1);
        mem_delay = 1;
        for (int i = 0; i < 10 && !obs_idv; i++) step(1'b1, 1, 0, 1'b0, 32'd0);
        check_eq("drain_rst_idpc", obs_idpc, RST_PC);

        // Randomized traffic: ready jitter, variable latency, sporadic redirects.
        mem_delay = 0;
        data_rand = 1'b1;
        for (int i = 0; i < 3000; i++)
            step(1'b1, 2, 2, 1'($urandom_range(0, 19) == 0), $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
